// File: rtl/add_sub_pipe_pkg.sv
// Shared types and constants for the pipelined adder/subtractor:
// operation encoding, saturation constants and small opcode decoders.
package add_sub_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDS = 2'b10,
        OP_SUBS = 2'b11
    } op_e;

    // Upper bound on supported operand width for the saturation constants.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] sat_max(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < width - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_W-1:0] sat_min(input int width);
        logic [MAX_W-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

    function automatic logic is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SUBS);
    endfunction

    function automatic logic is_sat(input op_e op);
        return (op == OP_ADDS) || (op == OP_SUBS);
    endfunction

endpackage

// File: rtl/add_sub_pipe_if.sv
// Valid/ready operand and result channel of the pipelined adder/subtractor.
interface add_sub_pipe_if
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    op_e              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, dataa, datab, op, out_ready,
        input  in_ready, out_valid, sum, carry, ovf, zero
    );

    modport slave (
        input  in_valid, dataa, datab, op, out_ready,
        output in_ready, out_valid, sum, carry, ovf, zero
    );

endinterface

// File: rtl/add_sub_pipe_seg.sv
// One SEG-bit slice of the carry chain plus its pipeline register. The value
// to register for the result/flags comes back from the parent so the last
// slice can latch the saturated result and final flags directly.
module add_sub_seg
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             valid_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] resSum_o,
    output logic             carrySum_o,
    input  logic [WIDTH-1:0] res_d_i,
    input  logic [2:0]       flags_d_i,
    output logic             valid_o,
    output op_e              op_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] res_o,
    output logic [2:0]       flags_o
);

    logic [SEG:0]     slice;
    logic             valid_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [2:0]       flags_q;

    always_comb begin
        slice = {1'b0, a_i[IDX*SEG +: SEG]} + {1'b0, b_i[IDX*SEG +: SEG]}
              + {{SEG{1'b0}}, carry_i};
        resSum_o = res_i;
        resSum_o[IDX*SEG +: SEG] = slice[SEG-1:0];
        carrySum_o = slice[SEG];
    end

    // The whole pipeline freezes together when the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            op_q    <= op_i;
            a_q     <= a_i;
            b_q     <= b_i;
            res_q   <= res_d_i;
            flags_q <= flags_d_i;
        end
    end

    assign valid_o = valid_q;
    assign op_o    = op_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign res_o   = res_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined WIDTH-bit adder/subtractor with optional signed saturation.
// The carry chain is cut into STAGES registered slices under one global stall.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input logic          clk,
    input logic          rst,
    add_sub_pipe_if.slave bus
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [MAX_W-1:0] SAT_MAX_W = sat_max(WIDTH);
    localparam logic [MAX_W-1:0] SAT_MIN_W = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX   = SAT_MAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN   = SAT_MIN_W[WIDTH-1:0];

    // Index k holds the inputs of stage k; index STAGES is the output register.
    logic             stgValid [STAGES+1];
    op_e              stgOp    [STAGES+1];
    logic [WIDTH-1:0] stgA     [STAGES+1];
    logic [WIDTH-1:0] stgB     [STAGES+1];
    logic [WIDTH-1:0] stgRes   [STAGES+1];
    logic [2:0]       stgFlags [STAGES+1];

    logic [WIDTH-1:0] resSum   [STAGES];
    logic             carrySum [STAGES];
    logic [WIDTH-1:0] resD     [STAGES];
    logic [2:0]       flagsD   [STAGES];

    logic             adv;
    logic             aMsb;
    logic             bMsb;
    logic             rMsb;
    logic             lastOvf;
    logic             lastCarry;
    logic             lastZero;
    logic [WIDTH-1:0] lastRes;

    assign adv = ~stgValid[STAGES] | bus.out_ready;

    // Subtraction is A + ~B + 1, so the op's low bit is both invert and carry-in.
    assign stgValid[0] = bus.in_valid;
    assign stgOp[0]    = bus.op;
    assign stgA[0]     = bus.dataa;
    assign stgB[0]     = is_sub(bus.op) ? ~bus.datab : bus.datab;
    assign stgRes[0]   = '0;
    assign stgFlags[0] = {is_sub(bus.op), 2'b00};

    always_comb begin
        aMsb      = stgA[LAST][WIDTH-1];
        bMsb      = stgB[LAST][WIDTH-1];
        rMsb      = resSum[LAST][WIDTH-1];
        lastOvf   = (aMsb == bMsb) && (rMsb != aMsb);
        lastCarry = is_sub(stgOp[LAST]) ? ~carrySum[LAST] : carrySum[LAST];
        lastRes   = resSum[LAST];
        if (is_sat(stgOp[LAST]) && lastOvf) begin
            lastRes = aMsb ? SAT_MIN : SAT_MAX;
        end
        lastZero  = (lastRes == '0);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == LAST) begin : g_last
            assign resD[k]   = lastRes;
            assign flagsD[k] = {lastCarry, lastOvf, lastZero};
        end else begin : g_mid
            assign resD[k]   = resSum[k];
            assign flagsD[k] = {carrySum[k], 2'b00};
        end

        add_sub_seg #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_seg (
            .clk        (clk),
            .rst        (rst),
            .adv_i      (adv),
            .valid_i    (stgValid[k]),
            .op_i       (stgOp[k]),
            .a_i        (stgA[k]),
            .b_i        (stgB[k]),
            .res_i      (stgRes[k]),
            .carry_i    (stgFlags[k][2]),
            .resSum_o   (resSum[k]),
            .carrySum_o (carrySum[k]),
            .res_d_i    (resD[k]),
            .flags_d_i  (flagsD[k]),
            .valid_o    (stgValid[k+1]),
            .op_o       (stgOp[k+1]),
            .a_o        (stgA[k+1]),
            .b_o        (stgB[k+1]),
            .res_o      (stgRes[k+1]),
            .flags_o    (stgFlags[k+1])
        );
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = stgValid[STAGES];
    assign bus.sum       = stgRes[STAGES];
    assign bus.carry     = stgFlags[STAGES][2];
    assign bus.ovf       = stgFlags[STAGES][1];
    assign bus.zero      = stgFlags[STAGES][0];

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=16, STAGES=2): directed vectors,
// backpressure, mid-flight reset and a randomized run against a reference model.
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    localparam int W      = 16;
    localparam int STAGES = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   retired;
    exp_t expQ[$];
    exp_t head;
    exp_t fresh;
    logic holdPending;
    logic [W-1:0] holdSum;
    logic holdC;
    logic holdO;
    logic holdZ;

    add_sub_pipe_if #(.WIDTH(W)) bus ();

    add_sub_pipe #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keeps the run bounded even if the handshake deadlocks.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference model built from plain integer arithmetic on the operand values.
    function automatic exp_t refModel(input logic [1:0] opv, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (opv[0]) begin
            full = ua - ub;
            r.c  = (ua < ub);
            sres = sa - sb;
        end else begin
            full = ua + ub;
            r.c  = (full > 65535);
            sres = sa + sb;
        end
        r.o   = (sres > 32767) || (sres < -32768);
        r.sum = full[15:0];
        if (opv[1] && r.o) begin
            r.sum = (sres > 0) ? 16'h7FFF : 16'h8000;
        end
        r.z = (r.sum == 16'h0000);
        return r;
    endfunction

    function automatic logic [W-1:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return W'($urandom());
        endcase
    endfunction

    // Drives one operation for a single cycle; called just after a rising edge
    // with the pipeline able to accept, returns just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] opv, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op_e'(opv);
        bus.dataa    = a;
        bus.datab    = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard on the falling edge: handshake rule, hold-while-stalled,
    // in-order result checking against the model, and flush on reset.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("hold_valid", bus.out_valid, 1);
                checkOutput("hold_sum",   bus.sum,   holdSum);
                checkOutput("hold_carry", bus.carry, holdC);
                checkOutput("hold_ovf",   bus.ovf,   holdO);
                checkOutput("hold_zero",  bus.zero,  holdZ);
            end
            checkOutput("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", bus.out_valid, 0);
                end else begin
                    head = expQ.pop_front();
                    checkOutput("sb_sum",   bus.sum,   head.sum);
                    checkOutput("sb_carry", bus.carry, head.c);
                    checkOutput("sb_ovf",   bus.ovf,   head.o);
                    checkOutput("sb_zero",  bus.zero,  head.z);
                    retired++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                fresh = refModel(bus.op, bus.dataa, bus.datab);
                expQ.push_back(fresh);
            end
            holdPending = bus.out_valid && !bus.out_ready;
            holdSum = bus.sum;
            holdC   = bus.carry;
            holdO   = bus.ovf;
            holdZ   = bus.zero;
        end
    end

    vec_t vecs[9];
    int   idx;
    int   startRet;
    logic lastAcc;

    initial begin
        checks = 0;
        fails = 0;
        retired = 0;
        holdPending = 1'b0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.op = OP_ADD;
        bus.dataa = '0;
        bus.datab = '0;
        bus.out_ready = 1'b0;

        vecs[0] = '{2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{2'b10, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b11, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{2'b10, 16'h0003, 16'hFFFE, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{2'b11, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b1};

        // Reset state, including in_ready while reset is still asserted.
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_sum", bus.sum, 0);
        checkOutput("rst_flags", {bus.carry, bus.ovf, bus.zero}, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready", bus.in_ready, 1);

        // Directed vectors with exact latency checks.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            for (int s = 1; s < STAGES; s++) begin
                checkOutput($sformatf("vec%0d_early", i), bus.out_valid, 0);
                @(posedge clk); #1;
            end
            checkOutput($sformatf("vec%0d_valid", i), bus.out_valid, 1);
            checkOutput($sformatf("vec%0d_sum", i),   bus.sum,   vecs[i].sum);
            checkOutput($sformatf("vec%0d_carry", i), bus.carry, vecs[i].c);
            checkOutput($sformatf("vec%0d_ovf", i),   bus.ovf,   vecs[i].o);
            checkOutput($sformatf("vec%0d_zero", i),  bus.zero,  vecs[i].z);
        end
        @(posedge clk); #1;

        // Backpressure: five ADDs with the consumer stalled for cycles 3..5.
        idx = 0;
        startRet = retired;
        for (int c = 0; c < 40; c++) begin
            bus.out_ready = !(c >= 3 && c <= 5);
            if (idx < 5) begin
                bus.in_valid = 1'b1;
                bus.op = OP_ADD;
                bus.dataa = W'(idx);
                bus.datab = 16'h0100;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (idx == 5 && retired - startRet == 5) break;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("bp_retired", retired - startRet, 5);

        // Reset with two operations in flight; nothing stale may surface.
        bus.out_ready = 1'b0;
        applyStimulus(2'b00, 16'h1111, 16'h2222);
        applyStimulus(2'b01, 16'h5555, 16'h1111);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        checkOutput("midrst_out_valid", bus.out_valid, 0);
        checkOutput("midrst_sum", bus.sum, 0);
        checkOutput("midrst_flags", {bus.carry, bus.ovf, bus.zero}, 0);
        checkOutput("midrst_in_ready", bus.in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput("midrst_no_stale", bus.out_valid, 0);
        end
        applyStimulus(2'b00, 16'h0001, 16'h0002);
        for (int s = 1; s < STAGES; s++) begin
            checkOutput("after_rst_early", bus.out_valid, 0);
            @(posedge clk); #1;
        end
        checkOutput("after_rst_valid", bus.out_valid, 1);
        checkOutput("after_rst_sum", bus.sum, 16'h0003);

        // Randomized traffic; a refused input is held until accepted.
        lastAcc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid || lastAcc) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                bus.op = op_e'($urandom_range(0, 3));
                bus.dataa = pickOperand();
                bus.datab = pickOperand();
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            lastAcc = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && expQ.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        checkOutput("drain_empty", expQ.size(), 0);
        @(posedge clk); #1;
        checkOutput("drain_out_valid", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
